econ_input_packer: RTL and testbench



---
 rtl/econ_pkg.sv | 13 +
 rtl/econ_input_packer_if.sv | 23 ++
 rtl/econ_frame_buf.sv | 36 +++
 rtl/econ_input_packer.sv | 76 +++++++
 tb/tb_econ_input_packer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/econ_pkg.sv
// Shared constants and types for the econV0 input packer.
// A frame is N_WORDS samples of WORD_W bits, with word 0 in the LSBs.
package econ_pkg;
    localparam int N_WORDS = 48;
    localparam int WORD_W  = 18;
    localparam int FRAME_W = N_WORDS * WORD_W;
    localparam int OUT_W   = 54;
    localparam int IDX_W   = $clog2(N_WORDS);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [IDX_W-1:0]   idx_t;
endpackage

// File: rtl/econ_input_packer_if.sv
// Sample stream in (s_*) and assembled-frame stream out (m_rsc_*), both valid/ready.
// slave is the packer's view, master is the neighbour/testbench view.
interface econ_input_packer_if;
    import econ_pkg::*;

    word_t  s_dat;
    logic   s_vld;
    logic   s_last;
    logic   s_rdy;
    frame_t m_rsc_dat;
    logic   m_rsc_vld;
    logic   m_rsc_rdy;

    modport slave (
        input  s_dat, s_vld, s_last, m_rsc_rdy,
        output s_rdy, m_rsc_dat, m_rsc_vld
    );

    modport master (
        output s_dat, s_vld, s_last, m_rsc_rdy,
        input  s_rdy, m_rsc_dat, m_rsc_vld
    );
endinterface

// File: rtl/econ_frame_buf.sv
// One frame register with indexed word write and a full flag; writes land next cycle.
// No backpressure of its own: the owner gates wr_en with the full flag.
module econ_frame_buf
    import econ_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   wr_en,
    input  idx_t   wr_idx,
    input  word_t  wr_dat,
    input  logic   set_full,
    input  logic   clr,
    output frame_t dat,
    output logic   full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dat  <= '0;
            full <= 1'b0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < N_WORDS; i++) begin
                    if (wr_idx == idx_t'(i))
                        dat[i*WORD_W +: WORD_W] <= wr_dat;
                end
            end
            // set and clr never coincide: set needs an empty buffer, clr a full one
            if (set_full)
                full <= 1'b1;
            else if (clr)
                full <= 1'b0;
        end
    end

endmodule

// File: rtl/econ_input_packer.sv
// Packs 48 serial samples into one frame over ping-pong buffers; frame valid the cycle after the 48th accept.
// s_rdy drops only when the buffer being filled is still waiting on the consumer; outputs are register-driven.
module econ_input_packer
    import econ_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    econ_input_packer_if.slave   bus,
    output logic                 err_len,
    output logic [CNT_W-1:0]     frame_cnt
);

    logic       wr_sel;
    logic       rd_sel;
    idx_t       wr_idx;
    logic [1:0] full;
    frame_t     frame_q [2];

    logic s_rdy;
    logic accept;
    logic last_word;
    logic handoff;

    assign s_rdy     = !full[wr_sel];
    assign accept    = bus.s_vld & s_rdy;
    assign last_word = (wr_idx == idx_t'(N_WORDS - 1));
    assign handoff   = full[rd_sel] & bus.m_rsc_rdy;

    assign bus.s_rdy     = s_rdy;
    assign bus.m_rsc_vld = full[rd_sel];
    assign bus.m_rsc_dat = frame_q[rd_sel];

    for (genvar b = 0; b < 2; b++) begin : g_buf
        econ_frame_buf u_buf (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (accept && (wr_sel == 1'(b))),
            .wr_idx   (wr_idx),
            .wr_dat   (bus.s_dat),
            .set_full (accept && last_word && (wr_sel == 1'(b))),
            .clr      (handoff && (rd_sel == 1'(b))),
            .dat      (frame_q[b]),
            .full     (full[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= '0;
            err_len   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // s_last must coincide exactly with the 48th word
            err_len <= accept & (last_word ^ bus.s_last);
            if (accept) begin
                if (last_word) begin
                    wr_sel <= ~wr_sel;
                    wr_idx <= '0;
                end else if (bus.s_last) begin
                    wr_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + idx_t'(1);
                end
            end
            if (handoff) begin
                rd_sel    <= ~rd_sel;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_econ_input_packer.sv
// Directed and randomised bench for econ_input_packer with a frame scoreboard.
module tb_econ_input_packer;
    import econ_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_len;
    logic [15:0] frame_cnt;

    econ_input_packer_if bus();

    logic rdy_ctl  = 1'b0;
    logic rnd_rdy  = 1'b0;
    logic rand_rdy = 1'b0;
    assign bus.m_rsc_rdy = rand_rdy ? rnd_rdy : rdy_ctl;

    econ_input_packer #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_len   (err_len),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q[$];
    frame_t mframe = '0;
    int     midx = 0;
    int     exp_err = 0;
    int     err_seen = 0;
    int     waits = 0;
    frame_t last_frame = '0;
    logic   prev_stall = 1'b0;
    frame_t prev_dat = '0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(string tag, frame_t obs, frame_t exp);
        int bad = 0;
        for (int i = N_WORDS - 1; i >= 0; i--)
            if (obs[i*WORD_W +: WORD_W] !== exp[i*WORD_W +: WORD_W]) bad = i;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: word %0d got 0x%0h expected 0x%0h", tag, bad,
                   obs[bad*WORD_W +: WORD_W], exp[bad*WORD_W +: WORD_W]);
        end
    endtask

    // Output monitor: scoreboard pop on handshake, hold check while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (err_len) err_seen++;
            if (prev_stall) begin
                chk("hold_vld", 64'(bus.m_rsc_vld), 64'd1);
                chk_frame("hold_dat", bus.m_rsc_dat, prev_dat);
            end
            if (bus.m_rsc_vld && bus.m_rsc_rdy) begin
                chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk_frame("frame_dat", bus.m_rsc_dat, exp_q.pop_front());
                last_frame = bus.m_rsc_dat;
            end
            prev_stall = bus.m_rsc_vld && !bus.m_rsc_rdy;
            prev_dat   = bus.m_rsc_dat;
        end
    end

    // Drive one sample and update the reference model once it is accepted.
    task automatic send_word(word_t d, bit last, bit gaps);
        int n = 0;
        bit got = 1'b0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.s_vld = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.s_vld  = 1'b1;
        bus.s_dat  = d;
        bus.s_last = last;
        while (!got && n < 2000) begin
            @(negedge clk);
            got = bus.s_rdy;
            @(posedge clk); #1;
            if (!got) begin
                n++;
                waits++;
            end
        end
        chk("accept_in_time", 64'(got), 64'd1);
        bus.s_vld  = 1'b0;
        bus.s_last = 1'b0;
        if (got) begin
            mframe[midx*WORD_W +: WORD_W] = d;
            if (midx == N_WORDS - 1) begin
                exp_q.push_back(mframe);
                if (!last) exp_err++;
                midx = 0;
            end else if (last) begin
                exp_err++;
                midx = 0;
            end else begin
                midx++;
            end
        end
    endtask

    task automatic send_frame(int base, int n, int last_at, bit gaps);
        for (int k = 0; k < n; k++) send_word(word_t'(base + k), k == last_at, gaps);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        midx = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_vld  = 1'b0;
        bus.s_dat  = '0;
        bus.s_last = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_rdy", 64'(bus.s_rdy), 64'd1);
        chk("rst_vld", 64'(bus.m_rsc_vld), 64'd0);
        chk("rst_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err", 64'(err_len), 64'd0);
        chk_frame("rst_dat", bus.m_rsc_dat, '0);
        rst = 1'b0;

        // 1: single frame, latency and word placement, then sustained throughput
        rdy_ctl = 1'b1;
        waits = 0;
        send_frame(1, 48, 47, 0);
        chk("t1_vld_latency", 64'(bus.m_rsc_vld), 64'd1);
        chk("t1_w0", 64'(bus.m_rsc_dat[17:0]), 64'd1);
        chk("t1_w1", 64'(bus.m_rsc_dat[35:18]), 64'd2);
        chk("t1_w47", 64'(bus.m_rsc_dat[863:846]), 64'd48);
        wait_drain("t1_drain");
        chk("t1_cnt", 64'(frame_cnt), 64'd1);
        send_frame(100, 48, 47, 0);
        send_frame(200, 48, 47, 0);
        wait_drain("t1_drain2");
        chk("t1_no_bubbles", 64'(waits), 64'd0);
        chk("t1_cnt3", 64'(frame_cnt), 64'd3);
        chk("t1_err", 64'(err_seen), 64'(exp_err));

        // 2: consumer stalled, both buffers fill, ordered release
        do_reset();
        rdy_ctl = 1'b0;
        send_frame(1000, 48, 47, 0);
        send_frame(2000, 48, 47, 0);
        chk("t2_s_rdy_full", 64'(bus.s_rdy), 64'd0);
        chk("t2_vld", 64'(bus.m_rsc_vld), 64'd1);
        chk("t2_f1_w0", 64'(bus.m_rsc_dat[17:0]), 64'd1000);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_f1_still", 64'(bus.m_rsc_dat[17:0]), 64'd1000);
        rdy_ctl = 1'b1;
        @(negedge clk);
        chk("t2_s_rdy_before", 64'(bus.s_rdy), 64'd0);
        @(posedge clk); #1;
        rdy_ctl = 1'b0;
        chk("t2_s_rdy_after", 64'(bus.s_rdy), 64'd1);
        chk("t2_f2_w0", 64'(bus.m_rsc_dat[17:0]), 64'd2000);
        send_frame(3000, 48, 47, 0);
        chk("t2_s_rdy_full2", 64'(bus.s_rdy), 64'd0);
        rdy_ctl = 1'b1;
        wait_drain("t2_drain");
        chk("t2_cnt", 64'(frame_cnt), 64'd3);

        // 3: early s_last discards the partial frame
        send_frame(32'h200, 11, 10, 0);
        @(posedge clk); #1;
        chk("t3_err", 64'(err_seen), 64'(exp_err));
        chk("t3_no_frame", 64'(bus.m_rsc_vld), 64'd0);
        chk("t3_cnt", 64'(frame_cnt), 64'd3);
        send_frame(32'h100, 48, 47, 0);
        wait_drain("t3_drain");
        chk("t3_w0", 64'(last_frame[17:0]), 64'h100);
        chk("t3_cnt2", 64'(frame_cnt), 64'd4);

        // 4: missing s_last still emits the frame
        send_frame(32'h300, 48, -1, 0);
        wait_drain("t4_drain");
        chk("t4_err", 64'(err_seen), 64'(exp_err));
        chk("t4_w47", 64'(last_frame[863:846]), 64'h32F);
        chk("t4_cnt", 64'(frame_cnt), 64'd5);

        // 5: reset mid-frame with a frame waiting
        rdy_ctl = 1'b0;
        send_frame(32'h400, 48, 47, 0);
        send_frame(32'h500, 20, -1, 0);
        rst = 1'b1;
        exp_q.delete();
        midx = 0;
        @(posedge clk); #1;
        chk("t5_vld", 64'(bus.m_rsc_vld), 64'd0);
        chk("t5_s_rdy", 64'(bus.s_rdy), 64'd1);
        chk("t5_cnt", 64'(frame_cnt), 64'd0);
        chk_frame("t5_dat", bus.m_rsc_dat, '0);
        rst = 1'b0;
        rdy_ctl = 1'b1;
        send_frame(32'h600, 48, 47, 0);
        wait_drain("t5_drain");
        chk("t5_w0", 64'(last_frame[17:0]), 64'h600);
        chk("t5_w47", 64'(last_frame[863:846]), 64'h62F);
        chk("t5_cnt2", 64'(frame_cnt), 64'd1);

        // 6: random stalls on both sides over 200 frames
        do_reset();
        rand_rdy = 1'b1;
        for (int f = 0; f < 200; f++)
            for (int k = 0; k < N_WORDS; k++)
                send_word(word_t'($urandom), k == N_WORDS - 1, 1);
        wait_drain("t6_drain");
        rand_rdy = 1'b0;
        rdy_ctl = 1'b0;
        @(posedge clk); #1;
        chk("t6_cnt", 64'(frame_cnt), 64'd200);
        chk("t6_err", 64'(err_seen), 64'(exp_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
